// File: rtl/booth_arb_pkg.sv
// booth_arb_pkg: shared state encoding, id-width helper and response record for booth_mult_arbiter
package booth_arb_pkg;
  typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;
  function automatic int idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  localparam int N_DEF = 16;
  localparam int NREQ_DEF = 4;
  typedef struct packed {
    logic signed [2*N_DEF-1:0] product;
    logic [idw(NREQ_DEF)-1:0] id;
  } rsp_t;
endpackage

// File: rtl/booth_mult_arbiter_if.sv
// booth_mult_arbiter_if: request/response bus between multiply clients (master) and the arbiter (slave)
interface booth_mult_arbiter_if #(
  parameter int N = 16,
  parameter int NREQ = 4,
  parameter int IDW = booth_arb_pkg::idw(NREQ)
);
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [NREQ*N-1:0] req_mr;
  logic [NREQ*N-1:0] req_mp;
  logic rsp_valid;
  logic rsp_ready;
  logic signed [2*N-1:0] rsp_product;
  logic [IDW-1:0] rsp_id;
  modport master(output req_valid, req_mr, req_mp, rsp_ready, input req_ready, rsp_valid, rsp_product, rsp_id);
  modport slave(input req_valid, req_mr, req_mp, rsp_ready, output req_ready, rsp_valid, rsp_product, rsp_id);
endinterface

// File: rtl/BoothModMultAlg.sv
// BoothModMultAlg: combinational radix-2 Booth signed multiplier, full 2n-bit product
module BoothModMultAlg #(
  parameter int n = 16
) (
  input  logic signed [n-1:0]   mr,
  input  logic signed [n-1:0]   mp,
  output logic signed [2*n-1:0] product
);
  logic [n:0] mrx;
  logic signed [2*n-1:0] mpx;
  assign mrx = {mr, 1'b0};
  assign mpx = (2*n)'(mp);
  always_comb begin
    product = '0;
    for (int i = 0; i < n; i++) begin
      product = (mrx[i+:2] == 2'b10) ? product - (mpx <<< i) :
                (mrx[i+:2] == 2'b01) ? product + (mpx <<< i) : product;
    end
  end
endmodule

// File: rtl/booth_mult_arbiter_rr_arb.sv
// booth_rr_arb: combinational round-robin pick starting at ptr; one-hot grant only when en
module booth_rr_arb #(
  parameter int NREQ = 4,
  localparam int IDW = booth_arb_pkg::idw(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  win
);
  logic hit;
  always_comb begin
    win = '0;
    hit = 1'b0;
    // scan farthest-first so the nearest request from ptr is the last to overwrite
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NREQ]) begin
        win = IDW'((int'(ptr) + k) % NREQ);
        hit = 1'b1;
      end
    end
    grant = (en && hit) ? NREQ'(1) << win : '0;
  end
endmodule

// File: rtl/booth_mult_arbiter.sv
// booth_mult_arbiter: round-robin sharing of one Booth multiplier among NREQ requesters.
// Define BOOTH_MULT_ARBITER_CHECK_EN to add the sticky chk_err self-check against a behavioural multiply.
module booth_mult_arbiter
  import booth_arb_pkg::*;
#(
  parameter int N = 16,
  parameter int NREQ = 4
) (
  input  logic clk,
  input  logic rst_n,
  booth_mult_arbiter_if.slave bus,
`ifdef BOOTH_MULT_ARBITER_CHECK_EN
  output logic chk_err,
`endif
  output logic busy
);
  localparam int IDW = idw(NREQ);
  state_t state_q, state_d;
  logic [IDW-1:0] rr_ptr, id_q, win, rsp_id_q;
  logic [NREQ-1:0] grant;
  logic signed [N-1:0] op_mr, op_mp;
  logic signed [2*N-1:0] prod, product_q;
  logic en, take;
  // rst_n gating keeps req_ready low while reset is held
  assign en = rst_n && (state_q == IDLE || (state_q == RESP && bus.rsp_ready));
  assign take = |grant;
  booth_rr_arb #(.NREQ(NREQ)) u_arb (.req(bus.req_valid), .ptr(rr_ptr), .en(en), .grant(grant), .win(win));
  BoothModMultAlg #(.n(N)) u_mult (.mr(op_mr), .mp(op_mp), .product(prod));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb
    state_d = (state_q == MUL) ? RESP :
              take ? MUL :
              (state_q == RESP && bus.rsp_ready) ? IDLE : state_q;
  always_comb begin
    bus.req_ready = grant;
    bus.rsp_valid = state_q == RESP;
    bus.rsp_product = product_q;
    bus.rsp_id = rsp_id_q;
    busy = state_q != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      op_mr <= '0;
      op_mp <= '0;
      id_q <= '0;
      product_q <= '0;
      rsp_id_q <= '0;
    end else begin
      if (take) begin
        op_mr <= bus.req_mr[win*N +: N];
        op_mp <= bus.req_mp[win*N +: N];
        id_q <= win;
        rr_ptr <= (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
      end
      if (state_q == MUL) begin
        product_q <= prod;
        rsp_id_q <= id_q;
      end
    end
  end
`ifdef BOOTH_MULT_ARBITER_CHECK_EN
  logic signed [2*N-1:0] ref_p;
  assign ref_p = (2*N)'(op_mr) * (2*N)'(op_mp);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) chk_err <= 1'b0;
    else if (state_q == MUL && prod != ref_p) chk_err <= 1'b1;
`ifndef SYNTHESIS
  always_ff @(posedge clk)
    if (rst_n && state_q == MUL && prod != ref_p)
      $error("booth product error id=%0d mr=%0d mp=%0d", id_q, op_mr, op_mp);
`endif
`endif
endmodule

// File: doc/booth_mult_arbiter.md
Name: booth_mult_arbiter

Overview:
- Shares one combinational `BoothModMultAlg` signed multiplier instance among NREQ requesters.
- Each requester presents signed operands on a valid/ready handshake.
- Round-robin arbitration selects one request at a time; the block registers its operands, drives the multiplier and returns a registered product tagged with the requester id over a single valid/ready response port.
- Sits between the multiply-issuing clients and the multiplier datapath.

Parameters:
- N, 16, operand width in bits; product width is 2N.
- NREQ, 4, number of requesters; range 2..8.
- IDW, $clog2(NREQ), requester id width (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester operand valid
- req_ready  out  NREQ  per-requester accept; one-hot or zero
- req_mr  in  NREQ*N  packed signed multipliers; slot i at [i*N +: N]
- req_mp  in  NREQ*N  packed signed multiplicands, same packing
- rsp_valid  out  1  product valid
- rsp_ready  in  1  consumer accepts product
- rsp_product  out  2N  signed product MR*MP
- rsp_id  out  IDW  index of requester that issued the product
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; rr_ptr=0; operand regs=0; req_ready=0; rsp_valid=0; rsp_product=0; rsp_id=0; busy=0.
- FSM states:
  - IDLE: req_ready = one-hot grant from the arbiter, zero if no req_valid. On grant, capture req_mr/req_mp of the winner into op_mr/op_mp and the winner index into id_q; go to MUL.
  - MUL (exactly 1 cycle): op_mr/op_mp drive BoothModMultAlg. Product registers into rsp_product and id_q into rsp_id. Go to RESP.
  - RESP: rsp_valid=1; rsp_product and rsp_id are held stable until rsp_ready.
    - rsp_ready=1 with no pending req_valid: go to IDLE.
    - rsp_ready=1 with any req_valid: grant and capture in the same cycle, req_ready asserted; go to MUL (back-to-back issue).
- Latency and throughput: accept edge to rsp_valid = 2 cycles; sustained throughput 1 product per 2 cycles when rsp_ready=1.
- Arbitration:
  - Round-robin from rr_ptr: winner = first i in rr_ptr, rr_ptr+1, ... (mod NREQ) with req_valid[i]=1.
  - On grant, rr_ptr <= winner+1 mod NREQ; rr_ptr is unchanged when there is no grant.
  - req_ready is asserted only in IDLE, or in RESP when rsp_ready=1.
- Handshakes:
  - A requester may drop req_valid while not granted; no state change results.
  - Operands are sampled only on the req_valid & req_ready cycle.
  - rsp_valid never drops without rsp_ready.
- Arithmetic: signed two's complement, full 2N-bit product, no truncation or saturation. -2^(N-1) * -2^(N-1) = 2^(2N-2) must be exact.
- Boundary conditions:
  - Single requester continuously valid: served every 2 cycles.
  - rr_ptr wraps NREQ-1 -> 0.
  - Reset asserted in MUL or RESP: the in-flight result is discarded and no rsp_valid is emitted after reset release until a new accept.

Optional Feature:
- Macro: BOOTH_MULT_ARBITER_CHECK_EN.
- Defined:
  - Adds output port chk_err (1 bit).
  - In MUL, the Booth product is compared against a behavioural op_mr*op_mp.
  - A mismatch sets chk_err, which is sticky until rst_n.
  - Adds a simulation-only $error carrying the id and operands.
- Undefined: port and comparator absent; all other behaviour is identical.

Decomposition:
- Package booth_arb_pkg:
  - state typedef {IDLE, MUL, RESP}.
  - localparam function for id width.
  - Response struct {product, id}.
- Sub-module booth_rr_arb (NREQ): inputs req, ptr, en; outputs one-hot grant and winner index. Purely combinational.
- BoothModMultAlg is instantiated unchanged with n=N.

Test Plan:
- req0 MR=3, MP=-5 alone, rsp_ready=1 -> req_ready[0] for 1 cycle; 2 cycles later rsp_valid, rsp_product=32'hFFFFFFF1, rsp_id=0.
- All four valid after reset (rr_ptr=0), operands MR=i+1, MP=100 -> responses in id order 0,1,2,3 with products 100,200,300,400; 8 cycles total.
- rsp_ready=0 for 5 cycles with a product pending, MR=-32768, MP=-32768 -> rsp_product held at 32'h40000000; all req_ready stay 0; the next grant occurs on the rsp_ready cycle.
- req3 then req1 valid with rr_ptr=2 -> req3 granted first, then req1; rr_ptr ends at 2.
- rst_n pulsed low in MUL -> all outputs return to reset values immediately; no rsp_valid until a new request.
- 200 random {MR,MP} pairs over random requesters with random rsp_ready -> every rsp_product equals MR*MP of its matching rsp_id, in issue order; chk_err stays 0 when BOOTH_MULT_ARBITER_CHECK_EN is defined.
